// File: rtl/edge_detector_win_adr_gen.sv
// Kernel-window read address generator: walks every window centre of a row-major image and
// streams the KSIZE*KSIZE neighbour addresses per centre over a valid/ready handshake.
module edge_detector_win_adr_gen #(
   parameter int unsigned X_SIZE = 100,
   parameter int unsigned Y_SIZE = 100,
   parameter int unsigned KSIZE  = 3,
   localparam int unsigned ADR_BITS = $clog2(X_SIZE * Y_SIZE),
   localparam int unsigned KI_BITS  = $clog2(KSIZE * KSIZE),
   localparam int unsigned X_BITS   = $clog2(X_SIZE),
   localparam int unsigned Y_BITS   = $clog2(Y_SIZE)
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                Start_i,
   input  logic                Mode_i,
   input  logic                Abort_i,
   input  logic                AdrReady_i,
   output logic                AdrValid_o,
   output logic [ADR_BITS-1:0] MemImgAdr_o,
   output logic [KI_BITS-1:0]  KerIdx_o,
   output logic                WinLast_o,
   output logic                FrameLast_o,
   output logic [X_BITS-1:0]   CtrX_o,
   output logic [Y_BITS-1:0]   CtrY_o,
   output logic                Busy_o,
   output logic                Done_o
);

   localparam int unsigned R      = (KSIZE - 1) / 2;
   localparam int unsigned K_BITS = $clog2(KSIZE);

   localparam logic [K_BITS-1:0]   K_LAST     = K_BITS'(KSIZE - 1);
   localparam logic [X_BITS-1:0]   X_R        = X_BITS'(R);
   localparam logic [Y_BITS-1:0]   Y_R        = Y_BITS'(R);
   localparam logic [X_BITS-1:0]   X_HI_CLAMP = X_BITS'(X_SIZE - 1);
   localparam logic [Y_BITS-1:0]   Y_HI_CLAMP = Y_BITS'(Y_SIZE - 1);
   localparam logic [X_BITS-1:0]   X_HI_SKIP  = X_BITS'(X_SIZE - 1 - R);
   localparam logic [Y_BITS-1:0]   Y_HI_SKIP  = Y_BITS'(Y_SIZE - 1 - R);
   localparam logic [X_BITS:0]     X_OFS      = (X_BITS + 1)'(R);
   localparam logic [Y_BITS:0]     Y_OFS      = (Y_BITS + 1)'(R);
   localparam logic [X_BITS:0]     X_MAX      = (X_BITS + 1)'(X_SIZE - 1);
   localparam logic [Y_BITS:0]     Y_MAX      = (Y_BITS + 1)'(Y_SIZE - 1);
   localparam logic [ADR_BITS-1:0] Y_STRIDE   = ADR_BITS'(Y_SIZE);
   localparam logic [KI_BITS-1:0]  K_STRIDE   = KI_BITS'(KSIZE);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic              mode_q, mode_d;
   logic [X_BITS-1:0] cx_q, cx_d;
   logic [Y_BITS-1:0] cy_q, cy_d;
   logic [K_BITS-1:0] kx_q, kx_d, ky_q, ky_d;

   logic [X_BITS-1:0] cx_hi;
   logic [Y_BITS-1:0] cy_lo, cy_hi;
   logic              last_kx, last_ky, last_cx, last_cy, win_last, frame_last, run;

   assign cx_hi      = mode_q ? X_HI_CLAMP : X_HI_SKIP;
   assign cy_lo      = mode_q ? '0 : Y_R;
   assign cy_hi      = mode_q ? Y_HI_CLAMP : Y_HI_SKIP;
   assign last_kx    = (kx_q == K_LAST);
   assign last_ky    = (ky_q == K_LAST);
   assign last_cx    = (cx_q == cx_hi);
   assign last_cy    = (cy_q == cy_hi);
   assign win_last   = last_kx & last_ky;
   assign frame_last = win_last & last_cx & last_cy;
   assign run        = (state_q == StRun);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= StIdle;
         mode_q  <= 1'b0;
         cx_q    <= '0;
         cy_q    <= '0;
         kx_q    <= '0;
         ky_q    <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         kx_q    <= kx_d;
         ky_q    <= ky_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      kx_d    = kx_q;
      ky_d    = ky_q;
      unique case (state_q)
         StIdle: begin
            if (Start_i && !Abort_i) begin
               state_d = StRun;
               mode_d  = Mode_i;
               cx_d    = Mode_i ? '0 : X_R;
               cy_d    = Mode_i ? '0 : Y_R;
               kx_d    = '0;
               ky_d    = '0;
            end
         end
         StRun: begin
            // Abort wins over a simultaneous final transfer: no Done for an aborted frame.
            if (Abort_i) begin
               state_d = StIdle;
            end else if (AdrReady_i) begin
               if (frame_last) state_d = StDone;
               if (last_ky) begin
                  ky_d = '0;
                  if (last_kx) begin
                     kx_d = '0;
                     if (last_cy) begin
                        cy_d = cy_lo;
                        cx_d = cx_q + 1'b1;
                     end else begin
                        cy_d = cy_q + 1'b1;
                     end
                  end else begin
                     kx_d = kx_q + 1'b1;
                  end
               end else begin
                  ky_d = ky_q + 1'b1;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   logic [X_BITS:0]       sx, sx_ofs;
   logic [Y_BITS:0]       sy, sy_ofs;
   logic [X_BITS-1:0]     nx;
   logic [Y_BITS-1:0]     ny;
   logic [ADR_BITS-1:0]   adr;
   logic [KI_BITS-1:0]    ker;

   // Neighbour coordinate = centre + k - R, clamped per axis (a no-op for interior centres).
   always_comb begin
      sx     = {1'b0, cx_q} + (X_BITS + 1)'(kx_q);
      sy     = {1'b0, cy_q} + (Y_BITS + 1)'(ky_q);
      sx_ofs = sx - X_OFS;
      sy_ofs = sy - Y_OFS;
      if (sx < X_OFS)       nx = '0;
      else if (sx_ofs > X_MAX) nx = X_MAX[X_BITS-1:0];
      else                  nx = sx_ofs[X_BITS-1:0];
      if (sy < Y_OFS)       ny = '0;
      else if (sy_ofs > Y_MAX) ny = Y_MAX[Y_BITS-1:0];
      else                  ny = sy_ofs[Y_BITS-1:0];
      adr = ADR_BITS'(nx) * Y_STRIDE + ADR_BITS'(ny);
      ker = KI_BITS'(kx_q) * K_STRIDE + KI_BITS'(ky_q);
   end

   assign AdrValid_o  = run;
   assign Busy_o      = run;
   assign Done_o      = (state_q == StDone);
   assign MemImgAdr_o = run ? adr : '0;
   assign KerIdx_o    = run ? ker : '0;
   assign WinLast_o   = run & win_last;
   assign FrameLast_o = run & frame_last;
   assign CtrX_o      = run ? cx_q : '0;
   assign CtrY_o      = run ? cy_q : '0;

endmodule

// File: tb/tb_edge_detector_win_adr_gen.sv
// Bench for edge_detector_win_adr_gen: a 4x5 K=3 instance and a 5x5 K=5 instance, checked
// against a queue of expected transfers built from a small reference model.
module tb_edge_detector_win_adr_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic a_start = 1'b0, a_mode = 1'b0, abort = 1'b0, ready = 1'b0;
   logic b_start = 1'b0, b_mode = 1'b0, b_abort = 1'b0;

   logic       a_valid, a_wl, a_fl, a_busy, a_done;
   logic [4:0] a_adr;
   logic [3:0] a_ker;
   logic [1:0] a_cx;
   logic [2:0] a_cy;

   logic       b_valid, b_wl, b_fl, b_busy, b_done;
   logic [4:0] b_adr;
   logic [4:0] b_ker;
   logic [2:0] b_cx;
   logic [2:0] b_cy;

   edge_detector_win_adr_gen #(.X_SIZE(4), .Y_SIZE(5), .KSIZE(3)) dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .Start_i(a_start), .Mode_i(a_mode), .Abort_i(abort),
      .AdrReady_i(ready), .AdrValid_o(a_valid), .MemImgAdr_o(a_adr), .KerIdx_o(a_ker),
      .WinLast_o(a_wl), .FrameLast_o(a_fl), .CtrX_o(a_cx), .CtrY_o(a_cy), .Busy_o(a_busy),
      .Done_o(a_done)
   );

   edge_detector_win_adr_gen #(.X_SIZE(5), .Y_SIZE(5), .KSIZE(5)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .Start_i(b_start), .Mode_i(b_mode), .Abort_i(b_abort),
      .AdrReady_i(ready), .AdrValid_o(b_valid), .MemImgAdr_o(b_adr), .KerIdx_o(b_ker),
      .WinLast_o(b_wl), .FrameLast_o(b_fl), .CtrX_o(b_cx), .CtrY_o(b_cy), .Busy_o(b_busy),
      .Done_o(b_done)
   );

   logic        sel = 1'b0;
   logic        o_valid, o_wl, o_fl, o_busy, o_done;
   logic [31:0] o_adr, o_ker, o_cx, o_cy;

   always_comb begin
      if (sel) begin
         o_valid = b_valid; o_wl = b_wl; o_fl = b_fl; o_busy = b_busy; o_done = b_done;
         o_adr = 32'(b_adr); o_ker = 32'(b_ker); o_cx = 32'(b_cx); o_cy = 32'(b_cy);
      end else begin
         o_valid = a_valid; o_wl = a_wl; o_fl = a_fl; o_busy = a_busy; o_done = a_done;
         o_adr = 32'(a_adr); o_ker = 32'(a_ker); o_cx = 32'(a_cx); o_cy = 32'(a_cy);
      end
   end

   typedef struct {
      int adr;
      int ker;
      bit wl;
      bit fl;
      int cx;
      int cy;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   log_adr[0:255];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input int xs, input int ys, input int k, input bit mode);
      int   r, xl, xh, yl, yh, nx, ny;
      exp_t e;
      r  = (k - 1) / 2;
      xl = mode ? 0 : r;
      xh = mode ? xs - 1 : xs - 1 - r;
      yl = mode ? 0 : r;
      yh = mode ? ys - 1 : ys - 1 - r;
      for (int cx = xl; cx <= xh; cx++)
         for (int cy = yl; cy <= yh; cy++)
            for (int kx = 0; kx < k; kx++)
               for (int ky = 0; ky < k; ky++) begin
                  nx = cx + kx - r;
                  ny = cy + ky - r;
                  if (nx < 0) nx = 0;
                  if (nx > xs - 1) nx = xs - 1;
                  if (ny < 0) ny = 0;
                  if (ny > ys - 1) ny = ys - 1;
                  e.adr = nx * ys + ny;
                  e.ker = kx * k + ky;
                  e.wl  = (kx == k - 1) && (ky == k - 1);
                  e.fl  = e.wl && (cx == xh) && (cy == yh);
                  e.cx  = cx;
                  e.cy  = cy;
                  sb.push_back(e);
               end
   endtask

   // Starts a frame and consumes transfers until FrameLast, stop_at transfers, or timeout.
   task automatic run_frame(input bit s, input bit m, input bit rnd, input int stop_at,
                            input int start_at, output int n);
      bit          got_last, stalled;
      logic [31:0] held_adr, held_ker, held_cx, held_cy;
      logic        held_wl, held_fl;
      logic [3:0]  pat;
      int          cyc;
      exp_t        e;
      pat = 4'b1001;
      got_last = 0; stalled = 0; cyc = 0; n = 0;
      held_adr = '0; held_ker = '0; held_cx = '0; held_cy = '0; held_wl = 0; held_fl = 0;
      sel = s;
      if (s) b_start = 1'b1;
      else begin
         a_mode  = m;
         a_start = 1'b1;
      end
      @(posedge clk); #1;
      a_start = 1'b0; b_start = 1'b0;
      chk("valid_after_start", 32'(o_valid), 1);
      while (!got_last && cyc < 2000 && !(stop_at > 0 && n == stop_at)) begin
         if (stalled) begin
            chk("stall_valid", 32'(o_valid), 1);
            chk("stall_adr", o_adr, held_adr);
            chk("stall_ker", o_ker, held_ker);
            chk("stall_tags", {28'd0, o_wl, o_fl, o_cx[0], o_cy[0]},
                {28'd0, held_wl, held_fl, held_cx[0], held_cy[0]});
         end
         if (rnd) ready = (cyc < 4) ? pat[3 - cyc] : 1'($urandom_range(0, 1));
         else begin
            ready = 1'b1;
            chk("no_bubble", 32'(o_valid), 1);
         end
         if (o_valid && ready) begin
            checks++;
            assert (sb.size() != 0) else begin
               errors++;
               $error("FAIL sb_underflow: observed extra transfer adr %0d expected none", o_adr);
            end
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("adr", o_adr, e.adr);
               chk("ker", o_ker, e.ker);
               chk("win_last", 32'(o_wl), 32'(e.wl));
               chk("frame_last", 32'(o_fl), 32'(e.fl));
               chk("ctr_x", o_cx, e.cx);
               chk("ctr_y", o_cy, e.cy);
            end
            log_adr[n & 255] = int'(o_adr);
            n++;
            if (o_fl) got_last = 1;
            stalled = 0;
         end else if (o_valid) begin
            stalled  = 1;
            held_adr = o_adr; held_ker = o_ker; held_cx = o_cx; held_cy = o_cy;
            held_wl  = o_wl;  held_fl  = o_fl;
         end
         if (!s && start_at > 0 && n == start_at) a_start = 1'b1;
         @(posedge clk); #1;
         a_start = 1'b0;
         cyc++;
      end
      ready = 1'b0;
      if (stop_at == 0) chk("frame_completed", 32'(got_last), 1);
   endtask

   task automatic post_frame();
      chk("done_pulse", 32'(o_done), 1);
      chk("busy_after_last", 32'(o_busy), 0);
      chk("valid_after_last", 32'(o_valid), 0);
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(o_done), 0);
      chk("sb_drained", sb.size(), 0);
   endtask

   int n;
   int first_skip[9]  = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
   int first_clamp[9] = '{0, 0, 1, 0, 0, 1, 5, 5, 6};

   initial begin
      #500000;
      $display("FAIL watchdog: observed simulation still running expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(a_valid), 0);
      chk("rst_busy", 32'(a_busy), 0);
      chk("rst_done", 32'(a_done), 0);
      chk("rst_adr", 32'(a_adr), 0);
      chk("rst_tags", {24'd0, a_ker, a_wl, a_fl, a_cx}, 0);
      chk("rst_cy", 32'(a_cy), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Skip mode, full throughput, with a Start pulse while busy.
      push_frame(4, 5, 3, 0);
      run_frame(0, 0, 0, 0, 10, n);
      chk("skip_count", n, 54);
      for (int i = 0; i < 9; i++) chk("skip_first_win", log_adr[i], first_skip[i]);
      chk("skip_last_adr", log_adr[53], 19);
      post_frame();

      // Clamp mode.
      push_frame(4, 5, 3, 1);
      run_frame(0, 1, 0, 0, 0, n);
      chk("clamp_count", n, 180);
      for (int i = 0; i < 9; i++) chk("clamp_first_win", log_adr[i], first_clamp[i]);
      chk("clamp_last_adr", log_adr[179], 19);
      post_frame();

      // Skip mode with back-pressure.
      push_frame(4, 5, 3, 0);
      run_frame(0, 0, 1, 0, 0, n);
      chk("stall_count", n, 54);
      post_frame();

      // Abort after 20 transfers, then a clean restart.
      push_frame(4, 5, 3, 0);
      run_frame(0, 0, 0, 20, 0, n);
      chk("abort_count", n, 20);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      sb.delete();
      chk("abort_valid", 32'(o_valid), 0);
      chk("abort_busy", 32'(o_busy), 0);
      for (int i = 0; i < 3; i++) begin
         chk("abort_no_done", 32'(o_done), 0);
         @(posedge clk); #1;
      end
      push_frame(4, 5, 3, 0);
      run_frame(0, 0, 0, 0, 0, n);
      chk("restart_count", n, 54);
      chk("restart_first_adr", log_adr[0], 0);
      post_frame();

      // Asynchronous reset mid-frame.
      push_frame(4, 5, 3, 1);
      run_frame(0, 1, 0, 7, 0, n);
      sb.delete();
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(a_valid), 0);
      chk("async_rst_busy", 32'(a_busy), 0);
      chk("async_rst_adr", 32'(a_adr), 0);
      chk("async_rst_tags", {24'd0, a_ker, a_wl, a_fl, a_cx}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("no_restart_after_rst", 32'(a_valid), 0);
      end

      // KSIZE=5 on a 5x5 image: single centre.
      push_frame(5, 5, 5, 0);
      run_frame(1, 0, 0, 0, 0, n);
      chk("k5_count", n, 25);
      for (int i = 0; i < 25; i++) chk("k5_adr_order", log_adr[i], i);
      post_frame();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/edge_detector_win_adr_gen.md
Name: edge_detector_win_adr_gen

Overview:
Sequential successor to the combinational pixel address mapper. On start it walks every kernel-window centre of an X_SIZE x Y_SIZE row-major image (address = x*Y_SIZE + y) and streams the KSIZE*KSIZE neighbour read addresses per centre over a valid/ready handshake, with window/frame tags. It sits between the edge-detector controller and the image memory read port. Border pixels are either skipped or clamped, selected per frame.

Parameters:
X_SIZE, 100, image extent in x (row index, outer dimension)
Y_SIZE, 100, image extent in y (inner dimension, address stride 1)
KSIZE, 3, kernel edge length; odd, 3..7; R=(KSIZE-1)/2; X_SIZE,Y_SIZE >= KSIZE

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
Start_i  in  1  start frame; accepted only in IDLE
Mode_i  in  1  border mode: 0=skip (interior centres only), 1=clamp (all centres, neighbours clamped); sampled on accepted start
Abort_i  in  1  synchronous abort, any state
AdrReady_i  in  1  consumer accepts current address
AdrValid_o  out  1  address/tags valid
MemImgAdr_o  out  ADR_BITS=$clog2(X_SIZE*Y_SIZE)  neighbour read address
KerIdx_o  out  $clog2(KSIZE*KSIZE)  kernel tap index
WinLast_o  out  1  last tap of current window
FrameLast_o  out  1  last tap of frame
CtrX_o  out  X_BITS=$clog2(X_SIZE)  current centre x
CtrY_o  out  Y_BITS=$clog2(Y_SIZE)  current centre y
Busy_o  out  1  high in RUN
Done_o  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset (async, rst_n_i=0): state IDLE; all counters 0; AdrValid_o, Busy_o, Done_o, WinLast_o, FrameLast_o = 0; MemImgAdr_o, KerIdx_o, CtrX_o, CtrY_o = 0. Release mid-frame: restarts only on a new Start_i.
- States: IDLE -> RUN on Start_i & !Abort_i; RUN -> DONE on handshake with FrameLast_o=1; RUN -> IDLE on Abort_i (no Done); DONE -> IDLE unconditionally (Done_o=1 for exactly that cycle).
- Start_i in RUN/DONE ignored. Abort_i in IDLE: no effect; Abort_i with Start_i in IDLE: stay IDLE.
- Latency: AdrValid_o=1 the cycle after the accepted start; all outputs registered/driven from registered counters.
- Handshake: transfer when AdrValid_o & AdrReady_i. While AdrValid_o & !AdrReady_i, every output held stable. One transfer per cycle at full throughput, no bubbles between windows or centres.
- Order: centre x outer, centre y inner; within window kx=-R..R outer, ky=-R..R inner. KerIdx_o=(kx+R)*KSIZE+(ky+R).
- Skip mode: centres x in R..X_SIZE-1-R, y in R..Y_SIZE-1-R; no clamping needed.
- Clamp mode: centres cover full image; neighbour coords clamped to [0,SIZE-1] per axis.
- Address = nx*Y_SIZE + ny, product computed at ADR_BITS width, no truncation for legal parameters.
- WinLast_o=1 when KerIdx_o=KSIZE*KSIZE-1; FrameLast_o=1 additionally at last centre.
- Total transfers: skip (X_SIZE-2R)*(Y_SIZE-2R)*KSIZE^2; clamp X_SIZE*Y_SIZE*KSIZE^2.

Test Plan:
- X_SIZE=4,Y_SIZE=5,KSIZE=3, Mode=0, ready=1 -> first window centre (1,1) addresses 0,1,2,5,6,7,10,11,12, WinLast on 12; 54 transfers; last address 19 with FrameLast; Done pulse 1 cycle later; Busy low after.
- Same image, Mode=1 -> centre (0,0) addresses 0,0,1,0,0,1,5,5,6; centre (3,4) last address 19; 180 transfers total, FrameLast only on 180th.
- Mode=0, AdrReady_i toggled 1,0,0,1 random -> outputs stable during stalls; sequence identical to ready=1 run; no duplicates or drops.
- Abort_i asserted at transfer 20 -> next cycle IDLE, AdrValid_o=0, no Done_o; following Start produces full sequence from address 0.
- Start_i pulsed while Busy_o=1 -> ignored, transfer count unchanged; rst_n_i low mid-frame -> all outputs 0 immediately (async), IDLE.
- KSIZE=5, X_SIZE=Y_SIZE=5, Mode=0 -> single centre (2,2), 25 transfers addresses 0..24 in order, WinLast and FrameLast both on 25th.
